// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB bus constants, completer FSM state type and address-range helper
package apb_pkg;

  localparam int APB_ADDR_W  = 9;
  localparam int APB_DATA_W  = 8;
  // PADDR bit the bridge decodes into PSEL1/PSEL2; bits below it are the local address
  localparam int APB_SEL_BIT = 8;
  localparam int APB_LOC_W   = APB_SEL_BIT;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ERR    = 2'd2
  } apb_state_e;

  function automatic logic addr_in_range(input logic [APB_LOC_W-1:0] addr, input int depth);
    return (int'(addr) < depth);
  endfunction

endpackage

// File: rtl/apb_slave_mem_array.sv
// rtl/apb_slave_mem_array.sv - DEPTH x 8 storage, one synchronous write port, one asynchronous read port
module apb_slave_mem_array
  import apb_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [APB_LOC_W-1:0]  waddr,
  input  logic [APB_DATA_W-1:0] wdata,
  input  logic [APB_LOC_W-1:0]  raddr,
  output logic [APB_DATA_W-1:0] rdata
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [APB_DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]      widx;
  logic [IDX_W-1:0]      ridx;

  assign widx = waddr[IDX_W-1:0];
  assign ridx = raddr[IDX_W-1:0];

  // Write port; out-of-range addresses never touch the array
  always_ff @(posedge clk) begin
    if (we && addr_in_range(waddr, DEPTH)) begin
      mem[widx] <= wdata;
    end
  end

  // Read port returns zero for addresses beyond the array
  always_comb begin
    rdata = '0;
    if (addr_in_range(raddr, DEPTH)) begin
      rdata = mem[ridx];
    end
  end

endmodule

// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB completer with 8-bit register-file memory; wait states built only with APB_SLV_WAIT_EN
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [APB_ADDR_W-1:0] PADDR,
  input  logic [APB_DATA_W-1:0] PWDATA,
  output logic [APB_DATA_W-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  apb_state_e            state_q, state_d;
  logic [APB_LOC_W-1:0]  addr_q, addr_d;
  logic                  wr_q, wr_d;
  logic [APB_DATA_W-1:0] wd_q, wd_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [APB_DATA_W-1:0] prdata_q, prdata_d;

  logic [APB_LOC_W-1:0]  loc_addr;
  logic [APB_LOC_W-1:0]  rd_addr;
  logic [APB_DATA_W-1:0] mem_rdata;
  logic                  commit;
  logic                  sel_bit_unused;

  // Upstream bridge has already decoded the select bit
  assign loc_addr       = PADDR[APB_LOC_W-1:0];
  assign sel_bit_unused = PADDR[APB_SEL_BIT];

`ifdef APB_SLV_WAIT_EN
  localparam logic [3:0] WAIT4 = 4'(WAIT_CYCLES);

  logic [3:0] cnt_q, cnt_d;
  logic       err_seen_q, err_seen_d;
  logic       mism;
  logic       err_now;

  // Bus signals must hold their setup values for the whole access phase
  assign mism = (loc_addr != addr_q) || (PWRITE != wr_q) || (wr_q && (PWDATA != wd_q));
`else
  localparam logic [3:0] wait_cycles_unused = 4'(WAIT_CYCLES);
`endif

  // In IDLE the setup address is looked up directly so zero-wait reads have data in the next cycle
  assign rd_addr = (state_q == ST_IDLE) ? loc_addr : addr_q;

  assign commit = (state_q == ST_ACCESS) && pready_q && PSEL && PENABLE && wr_q && !pslverr_q;

  apb_slave_mem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (PCLK),
    .we    (commit),
    .waddr (addr_q),
    .wdata (wd_q),
    .raddr (rd_addr),
    .rdata (mem_rdata)
  );

  // Next-state, latch and registered-response logic
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    wd_d      = wd_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
`ifdef APB_SLV_WAIT_EN
    cnt_d      = cnt_q;
    err_seen_d = err_seen_q;
    err_now    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d = ST_ACCESS;
          addr_d  = loc_addr;
          wr_d    = PWRITE;
          wd_d    = PWDATA;
`ifdef APB_SLV_WAIT_EN
          cnt_d      = WAIT4;
          err_seen_d = 1'b0;
          if (WAIT4 == 4'd0) begin
            pready_d  = 1'b1;
            pslverr_d = !addr_in_range(loc_addr, DEPTH);
            prdata_d  = (!PWRITE && addr_in_range(loc_addr, DEPTH)) ? mem_rdata : '0;
          end
`else
          pready_d  = 1'b1;
          pslverr_d = !addr_in_range(loc_addr, DEPTH);
          prdata_d  = (!PWRITE && addr_in_range(loc_addr, DEPTH)) ? mem_rdata : '0;
`endif
        end else if (PSEL && PENABLE) begin
          state_d   = ST_ERR;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
        end
      end
      ST_ACCESS: begin
`ifdef APB_SLV_WAIT_EN
        if (!PSEL || pready_q) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d      = cnt_q - 4'd1;
          err_now    = err_seen_q || mism;
          err_seen_d = err_now;
          if (cnt_q == 4'd1) begin
            pready_d  = 1'b1;
            pslverr_d = err_now || !addr_in_range(addr_q, DEPTH);
            prdata_d  = (!wr_q && !pslverr_d) ? mem_rdata : '0;
          end
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_ERR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and response registers; reset takes effect immediately
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wd_q      <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      wd_q      <= wd_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

`ifdef APB_SLV_WAIT_EN
  // Wait-state counter and sticky mismatch flag
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt_q      <= '0;
      err_seen_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      err_seen_q <= err_seen_d;
    end
  end
`endif

  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;
  assign PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb/tb_apb_slave_mem.sv - directed self-checking bench for two apb_slave_mem instances on one bus
module tb_apb_slave_mem;

`ifdef APB_SLV_WAIT_EN
  localparam int W0 = 3;
  localparam int W1 = 2;
`else
  localparam int W0 = 0;
  localparam int W1 = 0;
`endif

  logic       PCLK;
  logic       PRESETn;
  logic       psel1, psel2;
  logic       penable;
  logic       pwrite;
  logic [8:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata1, prdata2;
  logic       pready1, pready2;
  logic       pslverr1, pslverr2;

  int checks;
  int failures;
  int cyc;

  apb_slave_mem #(.DEPTH(256), .WAIT_CYCLES(3)) u_mem0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel1), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata1), .PREADY(pready1), .PSLVERR(pslverr1)
  );

  apb_slave_mem #(.DEPTH(64), .WAIT_CYCLES(2)) u_mem1 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel2), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata2), .PREADY(pready2), .PSLVERR(pslverr2)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Entered just after a rising edge; returns just after the edge that ends the PREADY cycle
  task automatic xfer(input bit sel, input bit wr, input logic [8:0] addr, input logic [7:0] wd,
                      input bit use_alt, input logic [8:0] alt_addr,
                      output logic [7:0] rd, output logic err, output int n);
    bit done;
    psel1   = !sel;
    psel2   = sel;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wd;
    @(posedge PCLK); #1;
    penable = 1'b1;
    if (use_alt) paddr = alt_addr;
    n    = 0;
    done = 1'b0;
    rd   = '0;
    err  = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge PCLK);
      n++;
      if ((sel ? pready2 : pready1) === 1'b1) begin
        done = 1'b1;
        rd   = sel ? prdata2 : prdata1;
        err  = sel ? pslverr2 : pslverr1;
      end
      @(posedge PCLK); #1;
    end
    if (!done) check_eq("xfer_timeout", 32'd0, 32'd1);
    psel1   = 1'b0;
    psel2   = 1'b0;
    penable = 1'b0;
  endtask

  logic [7:0] rd;
  logic       err;
  int         n;
  int         c0;
  bit         seen;

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    PRESETn  = 1'b0;
    psel1    = 1'b0;
    psel2    = 1'b0;
    penable  = 1'b0;
    pwrite   = 1'b0;
    paddr    = '0;
    pwdata   = '0;
    repeat (2) @(posedge PCLK);
    #1;
    check_eq("rst_pready0", 32'(pready1), 32'd0);
    check_eq("rst_pslverr0", 32'(pslverr1), 32'd0);
    check_eq("rst_prdata0", 32'(prdata1), 32'd0);
    check_eq("rst_pready1", 32'(pready2), 32'd0);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    check_eq("idle_pready0", 32'(pready1), 32'd0);

    xfer(0, 1, 9'h012, 8'hA5, 0, 9'h0, rd, err, n);
    check_eq("wr012_lat", n, W0 + 1);
    check_eq("wr012_err", 32'(err), 32'd0);
    xfer(0, 0, 9'h012, 8'h00, 0, 9'h0, rd, err, n);
    check_eq("rd012_lat", n, W0 + 1);
    check_eq("rd012_data", 32'(rd), 32'hA5);
    check_eq("rd012_err", 32'(err), 32'd0);

    xfer(0, 1, 9'h040, 8'h5A, 0, 9'h0, rd, err, n);
    xfer(0, 0, 9'h040, 8'h00, 0, 9'h0, rd, err, n);
    check_eq("rd040_lat", n, W0 + 1);
    check_eq("rd040_data", 32'(rd), 32'h5A);

    xfer(1, 1, 9'h150, 8'h77, 0, 9'h0, rd, err, n);
    check_eq("oor_wr_err", 32'(err), 32'd1);
    check_eq("oor_wr_lat", n, W1 + 1);
    xfer(1, 1, 9'h110, 8'h33, 0, 9'h0, rd, err, n);
    check_eq("inr_wr_err", 32'(err), 32'd0);
    xfer(1, 0, 9'h110, 8'h00, 0, 9'h0, rd, err, n);
    check_eq("inr_rd_data", 32'(rd), 32'h33);
    check_eq("inr_rd_err", 32'(err), 32'd0);
    xfer(1, 0, 9'h150, 8'h00, 0, 9'h0, rd, err, n);
    check_eq("oor_rd_err", 32'(err), 32'd1);
    check_eq("oor_rd_data", 32'(rd), 32'h00);

    psel1   = 1'b1;
    penable = 1'b1;
    pwrite  = 1'b1;
    paddr   = 9'h012;
    pwdata  = 8'hFF;
    @(negedge PCLK);
    check_eq("perr_pre_ready", 32'(pready1), 32'd0);
    @(posedge PCLK); #1;
    psel1   = 1'b0;
    penable = 1'b0;
    @(negedge PCLK);
    check_eq("perr_ready", 32'(pready1), 32'd1);
    check_eq("perr_slverr", 32'(pslverr1), 32'd1);
    check_eq("perr_prdata", 32'(prdata1), 32'd0);
    @(posedge PCLK); #1;
    @(negedge PCLK);
    check_eq("perr_idle", 32'(pready1), 32'd0);
    @(posedge PCLK); #1;
    xfer(0, 0, 9'h012, 8'h00, 0, 9'h0, rd, err, n);
    check_eq("perr_nowrite", 32'(rd), 32'hA5);

`ifdef APB_SLV_WAIT_EN
    xfer(0, 1, 9'h005, 8'h11, 0, 9'h0, rd, err, n);
    xfer(0, 1, 9'h006, 8'h22, 0, 9'h0, rd, err, n);
    xfer(0, 1, 9'h005, 8'h3C, 1, 9'h006, rd, err, n);
    check_eq("achg_err", 32'(err), 32'd1);
    xfer(0, 0, 9'h005, 8'h00, 0, 9'h0, rd, err, n);
    check_eq("achg_mem5", 32'(rd), 32'h11);
    xfer(0, 0, 9'h006, 8'h00, 0, 9'h0, rd, err, n);
    check_eq("achg_mem6", 32'(rd), 32'h22);
`endif

    psel1   = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 9'h012;
    pwdata  = 8'h99;
    @(posedge PCLK); #1;
    psel1   = 1'b0;
    @(negedge PCLK);
    check_eq("abort_err", 32'(pslverr1), 32'd0);
    @(posedge PCLK); #1;
    @(negedge PCLK);
    check_eq("abort_idle", 32'(pready1), 32'd0);
    @(posedge PCLK); #1;
    xfer(0, 0, 9'h012, 8'h00, 0, 9'h0, rd, err, n);
    check_eq("abort_nowrite", 32'(rd), 32'hA5);

    psel1   = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 9'h012;
    @(posedge PCLK); #1;
    penable = 1'b1;
    seen    = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge PCLK);
      if (pready1 === 1'b1) seen = 1'b1;
      else begin
        @(posedge PCLK); #1;
      end
    end
    if (!seen) check_eq("rst_mid_timeout", 32'd0, 32'd1);
    check_eq("rst_mid_data", 32'(prdata1), 32'hA5);
    #2;
    PRESETn = 1'b0;
    #1;
    check_eq("rst_mid_pready", 32'(pready1), 32'd0);
    check_eq("rst_mid_pslverr", 32'(pslverr1), 32'd0);
    check_eq("rst_mid_prdata", 32'(prdata1), 32'd0);
    psel1   = 1'b0;
    penable = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    @(posedge PCLK); #1;

    c0 = cyc;
    xfer(0, 1, 9'h001, 8'hC1, 0, 9'h0, rd, err, n);
    xfer(0, 1, 9'h002, 8'hC2, 0, 9'h0, rd, err, n);
    check_eq("b2b_cycles", cyc - c0, 2 * (2 + W0));
    xfer(0, 0, 9'h001, 8'h00, 0, 9'h0, rd, err, n);
    check_eq("b2b_mem1", 32'(rd), 32'hC1);
    xfer(0, 0, 9'h002, 8'h00, 0, 9'h0, rd, err, n);
    check_eq("b2b_mem2", 32'(rd), 32'hC2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
